// File: rtl/sc_frogger_gamectrl.sv
// Frogger game-flow controller: turns comparator event levels into game sequencing,
// register-bank reload strobes, the gameplay enable, and the lives/level display values.
module sc_frogger_gamectrl #(
    parameter int LIVES_INIT   = 3,
    parameter int LEVEL_MAX    = 4,
    parameter int PAUSE_CYCLES = 8
) (
    input  logic       SC_GAMECTRL_CLOCK_50,
    input  logic       SC_GAMECTRL_RESET_InHigh,
    input  logic       SC_GAMECTRL_Start_InLow,
    input  logic       SC_GAMECTRL_Lose_InHigh,
    input  logic       SC_GAMECTRL_Nest_InHigh,
    input  logic       SC_GAMECTRL_WinL_InHigh,
    input  logic [7:0] SC_GAMECTRL_NestRow_In,
    output logic       SC_GAMECTRL_ClearBack_OutHigh,
    output logic       SC_GAMECTRL_ClearPoint_OutHigh,
    output logic       SC_GAMECTRL_LoadNest_OutHigh,
    output logic [7:0] SC_GAMECTRL_NestRow_Out,
    output logic       SC_GAMECTRL_Enable_OutHigh,
    output logic [1:0] SC_GAMECTRL_Lives_Out,
    output logic [2:0] SC_GAMECTRL_Level_Out,
    output logic [2:0] SC_GAMECTRL_State_Out,
    output logic       SC_GAMECTRL_GameOver_OutHigh,
    output logic       SC_GAMECTRL_GameWon_OutHigh
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_DEAD     = 3'd3;
    localparam logic [2:0] ST_NESTED   = 3'd4;
    localparam logic [2:0] ST_LEVELUP  = 3'd5;
    localparam logic [2:0] ST_GAMEOVER = 3'd6;
    localparam logic [2:0] ST_WON      = 3'd7;

    localparam int               CNT_W      = $clog2(PAUSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [1:0]       LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [2:0]       LEVEL_LAST = 3'(LEVEL_MAX - 1);

    localparam int EV_LOSE = 0;
    localparam int EV_NEST = 1;
    localparam int EV_WIN  = 2;

    logic       clk;
    logic       srst;
    logic [2:0] lvl_in;
    logic [2:0] lvl_r_reg;
    logic [2:0] lvl_q_reg;
    logic [2:0] lvl_ev;
    logic       start_r_reg;
    logic       start_q_reg;
    logic       start_ev;
    logic [7:0] nest_row_r_reg;

    logic [2:0]       state_reg,       state_next;
    logic [CNT_W-1:0] cnt_reg,         cnt_next;
    logic [1:0]       lives_reg,       lives_next;
    logic [2:0]       level_reg,       level_next;
    logic [7:0]       nest_row_reg,    nest_row_next;
    logic             clear_back_reg,  clear_back_next;
    logic             clear_point_reg, clear_point_next;
    logic             load_nest_reg,   load_nest_next;
    logic             enable_reg;
    logic             gameover_reg;
    logic             won_reg;

    assign clk    = SC_GAMECTRL_CLOCK_50;
    assign srst   = SC_GAMECTRL_RESET_InHigh;
    assign lvl_in = {SC_GAMECTRL_WinL_InHigh, SC_GAMECTRL_Nest_InHigh, SC_GAMECTRL_Lose_InHigh};

    // Two-stage sampling: the first stage registers the raw levels, the second
    // remembers the previous sample, so a level already high never re-fires.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            assign lvl_ev[gi] = lvl_r_reg[gi] & ~lvl_q_reg[gi];
        end
    endgenerate

    assign start_ev = ~start_r_reg & start_q_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            lvl_r_reg      <= '0;
            lvl_q_reg      <= '0;
            start_r_reg    <= 1'b1;
            start_q_reg    <= 1'b1;
            nest_row_r_reg <= '0;
        end else begin
            lvl_r_reg      <= lvl_in;
            lvl_q_reg      <= lvl_r_reg;
            start_r_reg    <= SC_GAMECTRL_Start_InLow;
            start_q_reg    <= start_r_reg;
            nest_row_r_reg <= SC_GAMECTRL_NestRow_In;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        lives_next       = lives_reg;
        level_next       = level_reg;
        nest_row_next    = nest_row_reg;
        clear_back_next  = 1'b0;
        clear_point_next = 1'b0;
        load_nest_next   = 1'b0;

        case (state_reg)
            ST_IDLE, ST_GAMEOVER, ST_WON: begin
                if (start_ev) begin
                    state_next       = ST_START;
                    lives_next       = LIVES_LOAD;
                    level_next       = 3'd0;
                    clear_back_next  = 1'b1;
                    clear_point_next = 1'b1;
                end
            end
            ST_START: begin
                state_next = ST_PLAY;
            end
            ST_PLAY: begin
                // Lose beats win beats nest; the losers of a tie are dropped.
                if (lvl_ev[EV_LOSE]) begin
                    state_next = ST_DEAD;
                    lives_next = lives_reg - 2'd1;
                    cnt_next   = CNT_LOAD;
                end else if (lvl_ev[EV_WIN]) begin
                    state_next = ST_LEVELUP;
                    cnt_next   = CNT_LOAD;
                end else if (lvl_ev[EV_NEST]) begin
                    state_next     = ST_NESTED;
                    cnt_next       = CNT_LOAD;
                    nest_row_next  = nest_row_r_reg;
                    load_nest_next = 1'b1;
                end
            end
            ST_DEAD: begin
                if (cnt_reg == '0) begin
                    if (lives_reg == 2'd0) begin
                        state_next = ST_GAMEOVER;
                    end else begin
                        state_next       = ST_PLAY;
                        clear_point_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_NESTED: begin
                if (cnt_reg == '0) begin
                    state_next       = ST_PLAY;
                    clear_point_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_LEVELUP: begin
                if (cnt_reg == '0) begin
                    if (level_reg == LEVEL_LAST) begin
                        state_next = ST_WON;
                    end else begin
                        state_next       = ST_PLAY;
                        level_next       = level_reg + 3'd1;
                        clear_back_next  = 1'b1;
                        clear_point_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            lives_reg       <= '0;
            level_reg       <= '0;
            nest_row_reg    <= '0;
            clear_back_reg  <= 1'b0;
            clear_point_reg <= 1'b0;
            load_nest_reg   <= 1'b0;
            enable_reg      <= 1'b0;
            gameover_reg    <= 1'b0;
            won_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            lives_reg       <= lives_next;
            level_reg       <= level_next;
            nest_row_reg    <= nest_row_next;
            clear_back_reg  <= clear_back_next;
            clear_point_reg <= clear_point_next;
            load_nest_reg   <= load_nest_next;
            enable_reg      <= (state_next == ST_PLAY);
            gameover_reg    <= (state_next == ST_GAMEOVER);
            won_reg         <= (state_next == ST_WON);
        end
    end

    assign SC_GAMECTRL_ClearBack_OutHigh  = clear_back_reg;
    assign SC_GAMECTRL_ClearPoint_OutHigh = clear_point_reg;
    assign SC_GAMECTRL_LoadNest_OutHigh   = load_nest_reg;
    assign SC_GAMECTRL_NestRow_Out        = nest_row_reg;
    assign SC_GAMECTRL_Enable_OutHigh     = enable_reg;
    assign SC_GAMECTRL_Lives_Out          = lives_reg;
    assign SC_GAMECTRL_Level_Out          = level_reg;
    assign SC_GAMECTRL_State_Out          = state_reg;
    assign SC_GAMECTRL_GameOver_OutHigh   = gameover_reg;
    assign SC_GAMECTRL_GameWon_OutHigh    = won_reg;

endmodule
